// File: rtl/cf_fft_1024_8_reorder_pkg.sv
// ============================================================================
// Module  : cf_fft_1024_8_reorder_pkg
// Brief   : Shared defaults, bank/read state encodings and bit-reverse helper
//           for the FFT output reorder stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cf_fft_1024_8_reorder_pkg;

  localparam int c_log2n_default = 10;
  localparam int c_dw_default    = 16;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_state_t;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Reverses the low 'width' bits of v; bits at and above 'width' come back 0.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r[i] = v[width-1-i];
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cf_fft_1024_8_reorder_ram.sv
// ============================================================================
// Module  : cf_fft_reorder_ram
// Brief   : Simple dual-port RAM, one write port and one read port with a
//           registered (resettable) output.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cf_fft_reorder_ram
  import cf_fft_1024_8_reorder_pkg::*;
#(
  parameter int AW  = 11,
  parameter int DW2 = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_we,
  input  logic [AW-1:0]  i_waddr,
  input  logic [DW2-1:0] i_wdata,
  input  logic           i_re,
  input  logic [AW-1:0]  i_raddr,
  output logic [DW2-1:0] o_rdata
);

  logic [DW2-1:0] r_mem [0:(1<<AW)-1];
  logic [DW2-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // The read register is the block's output, so it must clear with reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/cf_fft_1024_8_reorder.sv
// ============================================================================
// Module  : cf_fft_1024_8_reorder
// Brief   : Bit-reversed to natural order reorder stage using a ping-pong
//           buffer. Optional macro CF_FFT_REORDER_BYPASS_EN adds a bypass port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cf_fft_1024_8_reorder
  import cf_fft_1024_8_reorder_pkg::*;
#(
  parameter int LOG2N = c_log2n_default,
  parameter int DW    = c_dw_default
) (
  input  logic          clock_c,
  input  logic          reset_c,
  input  logic          enable,
`ifdef CF_FFT_REORDER_BYPASS_EN
  input  logic          bypass,
`endif
  input  logic          in_valid,
  input  logic          in_sof,
  input  logic [DW-1:0] in_re,
  input  logic [DW-1:0] in_im,
  output logic          out_valid,
  output logic          out_sof,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im
);

  localparam int c_aw = LOG2N + 1;

  bank_state_t [1:0] r_bank;
  logic              r_wb;
  logic              r_rb;
  logic [LOG2N-1:0]  r_wcnt;
  logic [LOG2N-1:0]  r_rcnt;
  rd_state_t         r_rd_state;
  logic              r_out_valid;
  logic              r_out_sof;

  logic              w_byp;
  logic              w_wr_ok;
  logic              w_wr_last;
  logic              w_rd_issue;
  logic              w_rd_last;
  logic [LOG2N-1:0]  w_wcnt_cur;
  logic [LOG2N-1:0]  w_wcnt_nxt;
  logic [LOG2N-1:0]  w_waddr_lo;
  logic [2*DW-1:0]   w_ram_rdata;

  // A start-of-frame restarts the count so the sample lands at address 0.
  assign w_wcnt_cur = in_sof ? '0 : r_wcnt;
  assign w_wcnt_nxt = w_wcnt_cur + 1'b1;
  assign w_waddr_lo = LOG2N'(bitrev(32'(w_wcnt_cur), LOG2N));
  assign w_wr_last  = (w_wcnt_nxt == '0);
  assign w_wr_ok    = enable & in_valid & ~w_byp &
                      ((r_bank[r_wb] == BANK_EMPTY) | (r_bank[r_wb] == BANK_FILLING));

  // IDLE issues address 0 in the same cycle it sees a FULL bank.
  assign w_rd_issue = ~w_byp & ((r_rd_state == RD_READ) | (r_bank[r_rb] == BANK_FULL));
  assign w_rd_last  = &r_rcnt;

  cf_fft_reorder_ram #(
    .AW  (c_aw),
    .DW2 (2*DW)
  ) u_ram (
    .clk     (clock_c),
    .rst     (reset_c),
    .i_we    (w_wr_ok),
    .i_waddr ({r_wb, w_waddr_lo}),
    .i_wdata ({in_re, in_im}),
    .i_re    (enable),
    .i_raddr ({r_rb, r_rcnt}),
    .o_rdata (w_ram_rdata)
  );

  // Write and read sides only ever touch banks in disjoint states, so their
  // bank-state updates never collide.
  always_ff @(posedge clock_c or posedge reset_c) begin
    if (reset_c) begin
      r_bank      <= {BANK_EMPTY, BANK_EMPTY};
      r_wb        <= 1'b0;
      r_rb        <= 1'b0;
      r_wcnt      <= '0;
      r_rcnt      <= '0;
      r_rd_state  <= RD_IDLE;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
    end else if (enable) begin
      if (w_wr_ok) begin
        r_wcnt <= w_wcnt_nxt;
        if (w_wr_last) begin
          r_bank[r_wb] <= BANK_FULL;
          r_wb         <= ~r_wb;
        end else begin
          r_bank[r_wb] <= BANK_FILLING;
        end
      end

      if (w_rd_issue) begin
        if (w_rd_last) begin
          r_bank[r_rb] <= BANK_EMPTY;
          r_rb         <= ~r_rb;
          r_rcnt       <= '0;
          if (r_bank[~r_rb] == BANK_FULL) begin
            r_bank[~r_rb] <= BANK_DRAINING;
            r_rd_state    <= RD_READ;
          end else begin
            r_rd_state <= RD_IDLE;
          end
        end else begin
          r_rcnt     <= r_rcnt + 1'b1;
          r_rd_state <= RD_READ;
          if (r_rd_state == RD_IDLE) begin
            r_bank[r_rb] <= BANK_DRAINING;
          end
        end
      end

      if (w_byp) begin
        r_out_valid <= in_valid;
        r_out_sof   <= in_valid & in_sof;
      end else begin
        r_out_valid <= w_rd_issue;
        r_out_sof   <= w_rd_issue & (r_rcnt == '0);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;

`ifdef CF_FFT_REORDER_BYPASS_EN
  logic          r_byp_sel;
  logic [DW-1:0] r_byp_re;
  logic [DW-1:0] r_byp_im;

  assign w_byp = bypass;

  always_ff @(posedge clock_c or posedge reset_c) begin
    if (reset_c) begin
      r_byp_sel <= 1'b0;
      r_byp_re  <= '0;
      r_byp_im  <= '0;
    end else if (enable) begin
      r_byp_sel <= bypass;
      if (bypass) begin
        r_byp_re <= in_re;
        r_byp_im <= in_im;
      end
    end
  end

  assign out_re = r_byp_sel ? r_byp_re : w_ram_rdata[2*DW-1:DW];
  assign out_im = r_byp_sel ? r_byp_im : w_ram_rdata[DW-1:0];
`else
  assign w_byp  = 1'b0;
  assign out_re = w_ram_rdata[2*DW-1:DW];
  assign out_im = w_ram_rdata[DW-1:0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_cf_fft_1024_8_reorder.sv
// ============================================================================
// Module  : tb_cf_fft_1024_8_reorder
// Brief   : Self-checking bench for the reorder stage at LOG2N=3.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cf_fft_1024_8_reorder;

  localparam int LOG2N = 3;
  localparam int N     = 1 << LOG2N;
  localparam int DW    = 16;

  logic          clock_c = 1'b0;
  logic          reset_c = 1'b1;
  logic          enable  = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof  = 1'b0;
  logic [DW-1:0] in_re   = '0;
  logic [DW-1:0] in_im   = '0;
  logic          out_valid;
  logic          out_sof;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
`ifdef CF_FFT_REORDER_BYPASS_EN
  logic          bypass = 1'b0;
`endif

  cf_fft_1024_8_reorder #(.LOG2N(LOG2N), .DW(DW)) dut (
    .clock_c   (clock_c),
    .reset_c   (reset_c),
    .enable    (enable),
`ifdef CF_FFT_REORDER_BYPASS_EN
    .bypass    (bypass),
`endif
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  always #5 clock_c = ~clock_c;

  typedef struct {
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    bit            sof;
    int            due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] cur_q[$];
  int          ecyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          sof_seen = 0;
  bit          mon_on = 1'b0;

  // Index of the current enabled cycle; a disabled cycle does not advance it.
  always @(posedge clock_c) if (enable) ecyc <= ecyc + 1;

  function automatic int brev(input int v);
    int r;
    r = 0;
    for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  // Frame model: arrival position j carries bin brev(j); once a frame is
  // complete, bin k is due k enabled cycles after the 2-cycle latency.
  task automatic accept(input bit s, input logic [DW-1:0] re, input logic [DW-1:0] im);
    exp_t        e;
    logic [31:0] w;
    if (s) cur_q.delete();
    cur_q.push_back({re, im});
    if (cur_q.size() == N) begin
      for (int k = 0; k < N; k++) begin
        w     = cur_q[brev(k)];
        e.re  = w[31:16];
        e.im  = w[15:0];
        e.sof = (k == 0);
        e.due = ecyc + 2 + k;
        exp_q.push_back(e);
      end
      cur_q.delete();
    end
  endtask

  task automatic drive(input bit en, input bit v, input bit s,
                       input logic [DW-1:0] re, input logic [DW-1:0] im);
    @(posedge clock_c);
    #1;
    enable   = en;
    in_valid = v;
    in_sof   = s;
    in_re    = re;
    in_im    = im;
    if (en && v) accept(s, re, im);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 16'($urandom), 16'($urandom));
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic ramp_sample(input int j);
    logic [DW-1:0] re, im;
    re = 16'(j);
    im = 16'(-j);
    drive(1'b1, 1'b1, (j == 0), re, im);
  endtask

  task automatic check_drained(input string tag);
    checks++;
    assert (exp_q.size() == 0)
      else begin errors++; $error("FAIL %s: pending outputs got %0d expected 0", tag, exp_q.size()); end
  endtask

  // Output monitor, sampled on the falling edge.
  logic        prev_en = 1'b1;
  logic [33:0] prev_out;
  bit          prev_ok = 1'b0;

  always @(negedge clock_c) begin
    bit   ev;
    exp_t e;
    if (reset_c || !mon_on) begin
      prev_ok = 1'b0;
    end else begin
      if (prev_ok && !prev_en) begin
        checks++;
        assert ({out_valid, out_sof, out_re, out_im} === prev_out)
          else begin errors++; $error("FAIL hold: got %h expected %h", {out_valid, out_sof, out_re, out_im}, prev_out); end
      end
      if (enable) begin
        ev = (exp_q.size() > 0) && (exp_q[0].due == ecyc);
        checks++;
        assert (out_valid === ev)
          else begin errors++; $error("FAIL valid@%0d: got %b expected %b", ecyc, out_valid, ev); end
        if (ev) begin
          e = exp_q.pop_front();
          if (out_valid) begin
            checks++;
            assert ({out_re, out_im} === {e.re, e.im})
              else begin errors++; $error("FAIL data@%0d: got %h/%h expected %h/%h", ecyc, out_re, out_im, e.re, e.im); end
            checks++;
            assert (out_sof === e.sof)
              else begin errors++; $error("FAIL sof@%0d: got %b expected %b", ecyc, out_sof, e.sof); end
            if (out_sof) sof_seen++;
          end
        end
      end
      prev_en  = enable;
      prev_out = {out_valid, out_sof, out_re, out_im};
      prev_ok  = 1'b1;
    end
  end

  initial begin
    int sof_base;

    // Reset values
    #2;
    checks++;
    assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_valid: got %b expected 0", out_valid); end
    checks++;
    assert (out_sof === 1'b0) else begin errors++; $error("FAIL rst_sof: got %b expected 0", out_sof); end
    checks++;
    assert (out_re === 16'h0) else begin errors++; $error("FAIL rst_re: got %h expected 0", out_re); end
    checks++;
    assert (out_im === 16'h0) else begin errors++; $error("FAIL rst_im: got %h expected 0", out_im); end
    repeat (2) @(posedge clock_c);
    #1;
    reset_c = 1'b0;
    enable  = 1'b1;
    mon_on  = 1'b1;

    // Reorder of a ramp frame
    for (int j = 0; j < N; j++) ramp_sample(j);
    idle(N + 4);
    check_drained("reorder");

    // Back-to-back random frames
    sof_base = sof_seen;
    for (int f = 0; f < 4; f++)
      for (int j = 0; j < N; j++)
        drive(1'b1, 1'b1, (j == 0), 16'($urandom), 16'($urandom));
    idle(N + 4);
    check_drained("b2b");
    checks++;
    assert (sof_seen - sof_base == 4)
      else begin errors++; $error("FAIL b2b_sof: got %0d expected 4", sof_seen - sof_base); end

    // Enable stalls mid-input and mid-output
    for (int j = 0; j < N; j++) begin
      if (j == 4) stall(3);
      ramp_sample(j);
    end
    idle(4);
    stall(3);
    idle(N + 4);
    check_drained("stall");

    // Resync: partial frame discarded by a new start-of-frame
    for (int j = 0; j < 5; j++) drive(1'b1, 1'b1, (j == 0), 16'($urandom), 16'($urandom));
    for (int j = 0; j < N; j++) drive(1'b1, 1'b1, (j == 0), 16'($urandom), 16'($urandom));
    idle(N + 4);
    check_drained("resync");

    // Asynchronous reset during output
    for (int j = 0; j < N; j++) drive(1'b1, 1'b1, (j == 0), 16'($urandom), 16'($urandom));
    idle(5);
    @(posedge clock_c);
    #1;
    reset_c = 1'b1;
    exp_q.delete();
    cur_q.delete();
    #1;
    checks++;
    assert ({out_valid, out_sof, out_re, out_im} === 34'h0)
      else begin errors++; $error("FAIL async_rst: got %h expected 0", {out_valid, out_sof, out_re, out_im}); end
    #4;
    reset_c = 1'b0;
    for (int j = 0; j < N; j++) ramp_sample(j);
    idle(N + 4);
    check_drained("post_rst");

    // Random gaps and enable drops
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < N; j++) begin
        if ($urandom_range(0, 3) == 0) stall($urandom_range(1, 2));
        if ($urandom_range(0, 3) == 0) idle(1);
        drive(1'b1, 1'b1, (j == 0), 16'($urandom), 16'($urandom));
      end
    end
    for (int i = 0; i < 3 * N; i++) begin
      if ($urandom_range(0, 2) == 0) stall(1);
      else idle(1);
    end
    idle(N + 4);
    check_drained("random");

`ifdef CF_FFT_REORDER_BYPASS_EN
    // Bypass: arrival order, one cycle later
    mon_on = 1'b0;
    bypass = 1'b1;
    for (int j = 0; j <= N; j++) begin
      logic [DW-1:0] want;
      if (j < N) drive(1'b1, 1'b1, (j == 0), 16'(j), 16'(~j));
      else idle(1);
      if (j > 0) begin
        want = 16'(j - 1);
        checks++;
        assert (out_valid === 1'b1) else begin errors++; $error("FAIL byp_valid: got %b expected 1", out_valid); end
        checks++;
        assert (out_re === want) else begin errors++; $error("FAIL byp_re: got %h expected %h", out_re, want); end
        checks++;
        assert (out_sof === (j == 1)) else begin errors++; $error("FAIL byp_sof: got %b expected %b", out_sof, (j == 1)); end
      end
    end
    bypass = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
